// File: rtl/alu_operand_server.sv
// Operand server for the 4-bit bus ALU: holds the register file, issues ADDI/ADD,
// serves operand values on request and writes the ALU result and carry back.
module alu_operand_server #(
  parameter int NREGS   = 16,
  parameter int DW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [DW-1:0] instr_imm,
  input  logic [3:0]    instr_rd,
  input  logic [3:0]    instr_rs1,
  input  logic [3:0]    instr_rs2,
  output logic [3:0]    alu_opcode,
  output logic [DW-1:0] alu_mio,
  input  logic [3:0]    alu_bus_req,
  output logic [DW-1:0] alu_bus_to_alu,
  input  logic [DW-1:0] alu_bus_from_alu,
  output logic          alu_oe_n,
  input  logic          alu_done,
  input  logic          alu_carry,
  output logic          carry_flag,
  output logic          busy,
  output logic          err_illegal,
  output logic          err_timeout,
  input  logic [3:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, SERVE, DRAIN} state_t;

  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] REQ_NEXT = 4'b0011;
  localparam int         CW       = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d, rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d, src_q, src_d;
  logic [DW-1:0]   imm_q, imm_d, mio_q, mio_d, bus_q, bus_d;
  logic [3:0]      opcode_q, opcode_d, req_prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            switched_q, switched_d, oe_n_q, oe_n_d, carry_q, carry_d;
  logic            err_ill_q, err_ill_d, err_to_q, err_to_d, we;
  logic [DW-1:0]   regs_q [NREGS];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    src_d      = src_q;
    cnt_d      = cnt_q;
    switched_d = switched_q;
    opcode_d   = opcode_q;
    mio_d      = mio_q;
    bus_d      = bus_q;
    oe_n_d     = oe_n_q;
    carry_d    = carry_q;
    err_ill_d  = 1'b0;
    err_to_d   = 1'b0;
    we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d  = instr_op;
          imm_d = instr_imm;
          rd_d  = instr_rd;
          rs1_d = instr_rs1;
          rs2_d = instr_rs2;
          if (instr_op == OP_ADDI || instr_op == OP_ADD) state_d = ISSUE;
          else                                           err_ill_d = 1'b1;
        end
      end
      ISSUE: begin
        opcode_d   = op_q;
        mio_d      = (op_q == OP_ADDI) ? imm_q : '0;
        src_d      = (op_q == OP_ADDI) ? rs1_q : rs2_q;
        cnt_d      = '0;
        switched_d = 1'b0;
        oe_n_d     = 1'b0;
        bus_d      = regs_q[src_d];
        state_d    = SERVE;
      end
      SERVE: begin
        // ADD serves rs2 first; only the first fresh NEXT request moves to rs1
        if (op_q == OP_ADD && !switched_q && alu_bus_req == REQ_NEXT &&
            req_prev_q != REQ_NEXT) begin
          src_d      = rs1_q;
          switched_d = 1'b1;
        end
        bus_d = regs_q[src_d];
        if (alu_done) begin
          we       = (rd_q != 4'd0);
          carry_d  = alu_carry;
          opcode_d = '0;
          mio_d    = '0;
          oe_n_d   = 1'b1;
          bus_d    = '0;
          state_d  = DRAIN;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          opcode_d = '0;
          mio_d    = '0;
          oe_n_d   = 1'b1;
          bus_d    = '0;
          state_d  = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      src_q      <= '0;
      cnt_q      <= '0;
      switched_q <= 1'b0;
      req_prev_q <= '0;
      opcode_q   <= '0;
      mio_q      <= '0;
      bus_q      <= '0;
      oe_n_q     <= 1'b1;
      carry_q    <= 1'b0;
      err_ill_q  <= 1'b0;
      err_to_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      switched_q <= switched_d;
      req_prev_q <= alu_bus_req;
      opcode_q   <= opcode_d;
      mio_q      <= mio_d;
      bus_q      <= bus_d;
      oe_n_q     <= oe_n_d;
      carry_q    <= carry_d;
      err_ill_q  <= err_ill_d;
      err_to_q   <= err_to_d;
      if (we) regs_q[rd_q] <= alu_bus_from_alu;
    end
  end

  assign instr_ready    = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign alu_opcode     = opcode_q;
  assign alu_mio        = mio_q;
  assign alu_bus_to_alu = bus_q;
  assign alu_oe_n       = oe_n_q;
  assign carry_flag     = carry_q;
  assign err_illegal    = err_ill_q;
  assign err_timeout    = err_to_q;
  assign dbg_data       = (dbg_addr == 4'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_operand_server.sv
// Scoreboarded bench for alu_operand_server with a behavioural bus-ALU model.
module tb_alu_operand_server;

  logic       clk = 1'b0, rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = '0, instr_imm = '0, instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [3:0] alu_opcode, alu_mio, alu_bus_to_alu;
  logic       alu_oe_n, carry_flag, busy, err_illegal, err_timeout;
  logic [3:0] dbg_addr, dbg_data;
  logic [3:0] stim_addr = '0, mon_addr = '0;
  logic       mon_active = 1'b0;

  logic [3:0] m_req, m_from, m_first, m_second, m_mio;
  logic       m_done, m_carry, hang = 1'b0;
  int         m_st;

  int pass_cnt = 0, total_cnt = 0;

  typedef struct {
    int         kind;   // 0 ADDI, 1 ADD, 2 illegal, 3 timeout
    logic [3:0] rd, val, s1, s2, mio;
    logic       cf;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  assign dbg_addr = mon_active ? mon_addr : stim_addr;

  alu_operand_server dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_imm(instr_imm), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .alu_opcode(alu_opcode), .alu_mio(alu_mio), .alu_bus_req(m_req),
    .alu_bus_to_alu(alu_bus_to_alu), .alu_bus_from_alu(m_from), .alu_oe_n(alu_oe_n),
    .alu_done(m_done), .alu_carry(m_carry), .carry_flag(carry_flag), .busy(busy),
    .err_illegal(err_illegal), .err_timeout(err_timeout),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU model: read operand, (ADD) request next, read second, then pulse done
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_req <= '0; m_done <= 1'b0; m_from <= '0; m_carry <= 1'b0;
      m_first <= '0; m_second <= '0; m_mio <= '0;
    end else begin
      case (m_st)
        0: if (alu_opcode != 4'd0 && !alu_oe_n && !hang) begin
             m_req <= 4'b0001; m_st <= 1;
           end
        1: begin
             m_first <= alu_bus_to_alu;
             m_mio   <= alu_mio;
             if (alu_opcode == 4'd2) begin
               m_req <= 4'b0011; m_st <= 2;
             end else begin
               {m_carry, m_from} <= {1'b0, alu_bus_to_alu} + {1'b0, alu_mio};
               m_done <= 1'b1; m_req <= '0; m_st <= 9;
             end
           end
        2: begin m_req <= 4'b0001; m_st <= 3; end
        3: begin
             m_second <= alu_bus_to_alu;
             {m_carry, m_from} <= {1'b0, m_first} + {1'b0, alu_bus_to_alu};
             m_done <= 1'b1; m_req <= '0; m_st <= 9;
           end
        default: begin
             m_done <= 1'b0;
             if (alu_opcode == 4'd0) m_st <= 0;
           end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(int kind, logic [3:0] rd, logic [3:0] val, logic cf,
                              int cyc, logic [3:0] s1, logic [3:0] s2, logic [3:0] mio);
    exp_t e;
    e.kind = kind; e.rd = rd; e.val = val; e.cf = cf; e.cyc = cyc;
    e.s1 = s1; e.s2 = s2; e.mio = mio;
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, rd, rs1, rs2, imm, input exp_t e);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_ready) begin ok = 1; break; end
    end
    if (!ok) begin chk("issue_ready_timeout", 0, 1); return; end
    exp_q.push_back(e);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) return;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: pops an expectation on every completion, illegal or timeout event
  initial begin
    logic prev_oe;
    int   cyc;
    exp_t e;
    prev_oe = 1'b1; cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_oe = 1'b1; cyc = 0;
      end else begin
        if (!alu_oe_n) cyc++;
        if ((alu_oe_n && !prev_oe) || err_illegal) begin
          if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("err_timeout", err_timeout, e.kind == 3);
            chk("err_illegal", err_illegal, e.kind == 2);
            chk("carry_flag", carry_flag, e.cf);
            if (e.kind == 2) begin
              chk("illegal_busy", busy, 0);
              chk("illegal_opcode", alu_opcode, 0);
            end else begin
              chk("serve_cycles", cyc, e.cyc);
              if (e.kind <= 1) begin
                chk("served_first", m_first, e.s1);
                chk("alu_mio", m_mio, e.mio);
              end
              if (e.kind == 1) chk("served_second", m_second, e.s2);
              mon_addr = e.rd; mon_active = 1'b1;
              #1 chk("reg_value", dbg_data, e.val);
              mon_active = 1'b0;
            end
          end
          cyc = 0;
        end
        prev_oe = alu_oe_n;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_mio", alu_mio, 0);
    chk("rst_bus", alu_bus_to_alu, 0);
    chk("rst_oe_n", alu_oe_n, 1);
    chk("rst_carry", carry_flag, 0);
    chk("rst_errs", {err_illegal, err_timeout}, 0);

    issue(4'd1, 4'd3, 4'd0, 4'd0, 4'd5,  mk(0, 4'd3, 4'd5, 1'b0, 3, 4'd0, 4'd0, 4'd5));
    issue(4'd1, 4'd1, 4'd0, 4'd0, 4'd9,  mk(0, 4'd1, 4'd9, 1'b0, 3, 4'd0, 4'd0, 4'd9));
    issue(4'd1, 4'd2, 4'd0, 4'd0, 4'd8,  mk(0, 4'd2, 4'd8, 1'b0, 3, 4'd0, 4'd0, 4'd8));
    issue(4'd2, 4'd4, 4'd1, 4'd2, 4'd0,  mk(1, 4'd4, 4'd1, 1'b1, 5, 4'd8, 4'd9, 4'd0));
    issue(4'd1, 4'd6, 4'd0, 4'd0, 4'd1,  mk(0, 4'd6, 4'd1, 1'b0, 3, 4'd0, 4'd0, 4'd1));
    issue(4'd2, 4'd0, 4'd1, 4'd2, 4'd0,  mk(1, 4'd0, 4'd0, 1'b1, 5, 4'd8, 4'd9, 4'd0));
    issue(4'd2, 4'd3, 4'd3, 4'd3, 4'd0,  mk(1, 4'd3, 4'hA, 1'b0, 5, 4'd5, 4'd5, 4'd0));
    wait_done();

    issue(4'd7, 4'd5, 4'd1, 4'd2, 4'd3,  mk(2, 4'd5, 4'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0));
    @(negedge clk);
    @(negedge clk);
    chk("illegal_pulse_width", err_illegal, 0);
    chk("illegal_stays_idle", busy, 0);

    hang = 1'b1;
    issue(4'd1, 4'd4, 4'd1, 4'd0, 4'd2,  mk(3, 4'd4, 4'd1, 1'b0, 15, 4'd0, 4'd0, 4'd0));
    wait_done();
    hang = 1'b0;

    issue(4'd1, 4'd5, 4'd3, 4'd0, 4'd12, mk(0, 4'd5, 4'd6, 1'b1, 3, 4'hA, 4'd0, 4'd12));
    wait_done();

    issue(4'd2, 4'd7, 4'd1, 4'd2, 4'd0,  mk(1, 4'd7, 4'd1, 1'b1, 5, 4'd8, 4'd9, 4'd0));
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!alu_oe_n) begin seen = 1; break; end
    end
    chk("reached_serve", seen, 1);
    stim_addr = 4'd1;
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_opcode", alu_opcode, 0);
    chk("midrst_bus", alu_bus_to_alu, 0);
    chk("midrst_oe_n", alu_oe_n, 1);
    chk("midrst_carry", carry_flag, 0);
    chk("midrst_busy_ready", {busy, instr_ready}, 2'b01);
    chk("midrst_dbg_r1", dbg_data, 0);
    @(posedge clk);
    #1 chk("midrst_held", {busy, alu_opcode, alu_oe_n}, 6'b000001);
    @(negedge clk);
    rst = 1'b0;
    stim_addr = 4'd7;
    #1 chk("midrst_no_writeback_r7", dbg_data, 0);

    issue(4'd1, 4'd2, 4'd1, 4'd0, 4'd4,  mk(0, 4'd2, 4'd4, 1'b0, 3, 4'd0, 4'd0, 4'd4));
    wait_done();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
